// File: rtl/pipe_issue_ctrl_if.sv
// ID->EX issue handshake, WB retire, flush and status bundle for pipe_issue_ctrl.
// master = pipeline side (ID/EXU/WB), slave = issue controller.
interface pipe_issue_ctrl_if #(
  parameter int IDX_W        = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_W      = 32
);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

  logic             id_valid_i;
  logic             id_rs1_ren_i;
  logic [IDX_W-1:0] id_rs1_idx_i;
  logic             id_rs2_ren_i;
  logic [IDX_W-1:0] id_rs2_idx_i;
  logic             id_rd_wen_i;
  logic [IDX_W-1:0] id_rd_idx_i;
  logic             id_fence_i;
  logic             id_ready_o;
  logic             ex_ready_i;
  logic             ex_valid_o;
  logic             wb_valid_i;
  logic             wb_rd_wen_i;
  logic [IDX_W-1:0] wb_rd_idx_i;
  logic             flush_i;
  logic [IF_W-1:0]  inflight_o;
  logic             fence_busy_o;
  logic             err_o;
  logic [STALL_W-1:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i, id_rs2_idx_i,
           id_rd_wen_i, id_rd_idx_i, id_fence_i, ex_ready_i,
           wb_valid_i, wb_rd_wen_i, wb_rd_idx_i, flush_i,
    input  id_ready_o, ex_valid_o, inflight_o, fence_busy_o, err_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i, id_rs2_idx_i,
           id_rd_wen_i, id_rd_idx_i, id_fence_i, ex_ready_i,
           wb_valid_i, wb_rd_wen_i, wb_rd_idx_i, flush_i,
    output id_ready_o, ex_valid_o, inflight_o, fence_busy_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Scoreboarded ID->EX issue gate: zero-latency pass-through, no payload storage.
// Backpressure: id_ready drops on RAW hazard, rd saturation, in-flight limit, pending fence, flush or !ex_ready.
module pipe_issue_ctrl #(
  parameter int NREG         = 32,
  parameter int IDX_W        = 5,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_W      = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  pipe_issue_ctrl_if.slave bus
);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] INF_MAX = IF_W'(MAX_INFLIGHT);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pend_q [NREG];
  logic [IF_W-1:0]    inflight_q;
  logic               err_q;
  logic [STALL_W-1:0] stall_q;

  logic            hazard, sat, full, fblk, can, issue;
  logic            rd_trk, wb_trk, under_pend, under_inf;
  logic [NREG-1:0] inc_vec, dec_vec;

  // Hazard checks see only registered pend: a retire unblocks its consumer one cycle later.
  always_comb begin
    hazard     = (bus.id_rs1_ren_i && bus.id_rs1_idx_i != '0 && pend_q[bus.id_rs1_idx_i] != '0) ||
                 (bus.id_rs2_ren_i && bus.id_rs2_idx_i != '0 && pend_q[bus.id_rs2_idx_i] != '0);
    rd_trk     = bus.id_rd_wen_i && bus.id_rd_idx_i != '0;
    sat        = rd_trk && pend_q[bus.id_rd_idx_i] == '1;
    full       = inflight_q == INF_MAX;
    fblk       = bus.id_fence_i && inflight_q != '0;
    can        = rst_i && bus.ex_ready_i && !hazard && !sat && !full && !fblk && !bus.flush_i;
    issue      = bus.id_valid_i && can;
    wb_trk     = bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_rd_idx_i != '0;
    under_pend = wb_trk && pend_q[bus.wb_rd_idx_i] == '0;
    under_inf  = bus.wb_valid_i && inflight_q == '0;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && rd_trk) inc_vec[bus.id_rd_idx_i] = 1'b1;
    if (wb_trk)          dec_vec[bus.wb_rd_idx_i] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.id_valid_i && bus.id_fence_i && inflight_q != '0 && !bus.flush_i)
                  state_d = ST_DRAIN;
      ST_DRAIN: if (bus.flush_i || (issue && bus.id_fence_i))
                  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      inflight_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | under_pend | under_inf;
      if (bus.id_valid_i && !issue && stall_q != '1)
        stall_q <= stall_q + STALL_W'(1);
      if (bus.flush_i)
        inflight_q <= '0;
      else if (issue && !bus.wb_valid_i)
        inflight_q <= inflight_q + IF_W'(1);
      else if (!issue && bus.wb_valid_i && inflight_q != '0)
        inflight_q <= inflight_q - IF_W'(1);
    end
  end

  // Underflowing counters hold at zero; x0 is never tracked.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (bus.flush_i || r == 0)
          pend_q[r] <= '0;
        else if (inc_vec[r] && !dec_vec[r])
          pend_q[r] <= pend_q[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && pend_q[r] != '0)
          pend_q[r] <= pend_q[r] - CNT_W'(1);
      end
    end
  end

  assign bus.id_ready_o   = can;
  assign bus.ex_valid_o   = issue;
  assign bus.inflight_o   = inflight_q;
  assign bus.fence_busy_o = (state_q == ST_DRAIN);
  assign bus.err_o        = err_q;
  assign bus.stall_cnt_o  = stall_q;

  id_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (bus.id_valid_i && !bus.id_ready_o && !bus.flush_i) |=>
    (!bus.id_valid_i || $stable({bus.id_rs1_ren_i, bus.id_rs1_idx_i, bus.id_rs2_ren_i,
                                 bus.id_rs2_idx_i, bus.id_rd_wen_i, bus.id_rd_idx_i,
                                 bus.id_fence_i})));
endmodule
